// File: rtl/gray_seq_gen_pkg.sv
// Shared definitions for the Gray-code sequence generator.
// Holds the FSM state encoding and the default code width.
// Imported by gray_seq_gen and bin_to_gray.
package gray_seq_gen_pkg;

    // Default code width in bits (legal range 2..16).
    localparam int DATA_LEN_DEF = 5;

    // Two-state sequencer encoding.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gray_seq_gen_bin_to_gray.sv
// Purpose : combinational binary-to-Gray mapping, gray = bin ^ (bin >> 1).
// Latency : zero (pure combinational); registering is the caller's job.
// Backpressure: none; ports are bin (binary in) and gray (Gray out).
module bin_to_gray
    import gray_seq_gen_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic [DATA_LEN-1:0] bin,
    output logic [DATA_LEN-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_gen.sv
// Purpose : up/down Gray-code sequence generator, continuous or single pass.
// Latency : out_gray is registered from the next count, so it changes on the
//           same edge as the count; wrap/done are one-cycle registered pulses.
// Backpressure: valid/ready; the count only advances on out_valid & out_ready
//           and holds (with out_gray) otherwise.
// Ports   : clk, rst (async, active high); controls start/stop/dir/mode/load,
//           load_val; stream out_gray/out_valid/out_ready; status busy/wrap/done.
module gray_seq_gen
    import gray_seq_gen_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic                mode,
    input  logic                load,
    input  logic [DATA_LEN-1:0] load_val,
    output logic [DATA_LEN-1:0] out_gray,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                wrap,
    output logic                done
);

    localparam logic [DATA_LEN-1:0] ONE = DATA_LEN'(1);

    state_t              state;
    logic                dir_q;
    logic                mode_q;
    logic [DATA_LEN-1:0] count;
    logic [DATA_LEN-1:0] count_nxt;
    logic [DATA_LEN-1:0] step_val;
    logic [DATA_LEN-1:0] gray_nxt;
    logic                xfer;
    logic                at_term;
    logic                pass_end;

    assign xfer     = (state == RUN) & out_ready;
    // Terminal value depends on the latched direction: all-ones going up,
    // zero going down.
    assign at_term  = dir_q ? (count == '0) : (count == '1);
    // Single pass finishing: count must stay parked on the terminal value.
    assign pass_end = xfer & at_term & mode_q;
    // Modulo 2^DATA_LEN arithmetic makes the continuous-mode wrap implicit.
    assign step_val = dir_q ? (count - ONE) : (count + ONE);

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);

    always_comb begin
        count_nxt = count;
        if (state == IDLE) begin
            if (load) begin
                count_nxt = load_val;
            end
        end else if (xfer && !pass_end) begin
            count_nxt = step_val;
        end
    end

    // Gray code is taken from the next count so the out_gray register
    // tracks count with no extra cycle of delay.
    bin_to_gray #(
        .DATA_LEN (DATA_LEN)
    ) u_bin_to_gray (
        .bin  (count_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dir_q    <= 1'b0;
            mode_q   <= 1'b0;
            count    <= '0;
            out_gray <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            count    <= count_nxt;
            out_gray <= gray_nxt;
            wrap     <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        dir_q  <= dir;
                        mode_q <= mode;
                    end
                end
                RUN: begin
                    if (stop || pass_end) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (xfer && at_term) begin
                        // Only continuous mode reaches here on the terminal
                        // value; a stop on the same cycle suppresses the pulse.
                        wrap <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gray_seq_gen.md
GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

Interface
REQ-001 The module SHALL have parameter: DATA_LEN, 5, code width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  begin sequencing; honoured in IDLE only.
REQ-005 Port: stop  input  1  abort sequencing; honoured in RUN only.
REQ-006 Port: dir  input  1  0 = count up, 1 = count down; sampled on the cycle start is accepted.
REQ-007 Port: mode  input  1  0 = continuous (wraps), 1 = single pass; sampled on the cycle start is accepted.
REQ-008 Port: load  input  1  load the binary counter from load_val; honoured in IDLE only.
REQ-009 Port: load_val  input  DATA_LEN  binary start value.
REQ-010 Port: out_gray  output  DATA_LEN  registered Gray code of the current count.
REQ-011 Port: out_valid  output  1  out_gray is valid.
REQ-012 Port: out_ready  input  1  consumer accepts out_gray.
REQ-013 Port: busy  output  1  high while in RUN.
REQ-014 Port: wrap  output  1  one-cycle pulse; the terminal value transferred in continuous mode.
REQ-015 Port: done  output  1  one-cycle pulse; single pass completed or stop honoured.

Function
REQ-016 The FSM SHALL have two states, IDLE and RUN.
REQ-017 IDLE -> RUN SHALL occur on the rising edge on which start=1; dir and mode SHALL be latched on that edge.
REQ-018 In RUN, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0.
REQ-019 A transfer SHALL be out_valid & out_ready; only a transfer advances the count.
REQ-020 On a transfer, the count SHALL step by +1 (dir=0) or -1 (dir=1), modulo 2^DATA_LEN.
REQ-021 Without a transfer, the count and out_gray SHALL hold stable.
REQ-022 out_gray SHALL equal count ^ (count >> 1) and be registered, so that it changes on the same edge as count, with zero added latency.
REQ-023 The terminal value SHALL be all-ones for up-counting and zero for down-counting.
REQ-024 In continuous mode, a transfer of the terminal value SHALL wrap the count (to 0 or all-ones respectively), pulse wrap for one cycle, and remain in RUN.
REQ-025 In single-pass mode, a transfer of the terminal value SHALL return to IDLE, pulse done, and leave count at the terminal value.
REQ-026 A stop in RUN SHALL return to IDLE on the next edge and pulse done. A transfer on that same cycle SHALL still advance the count, with no wrap pulse generated.
REQ-027 In RUN, a start or a load SHALL be ignored.
REQ-028 In IDLE, a load SHALL set count to load_val on the next edge.
REQ-029 A simultaneous load and start in IDLE SHALL both take effect, so the first emitted value is gray(load_val).
REQ-030 A single pass started at the terminal value SHALL emit exactly one word, then finish.
REQ-031 busy SHALL equal (state == RUN).

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE, count=0, out_gray=0, out_valid=0, busy=0, wrap=0, done=0, latched dir=0 and latched mode=0, including during RUN.
REQ-033 After rst deasserts, no transfer, wrap or done SHALL occur until a new start.

Structure
REQ-034 A shared package/header SHALL hold the state encoding constants (IDLE=1'b0, RUN=1'b1) and the default DATA_LEN.
REQ-035 The binary-to-Gray mapping SHALL be one combinational sub-module, bin_to_gray, parameterised by DATA_LEN, feeding the out_gray register.

Verification (DATA_LEN=5)
REQ-036 Continuous up from reset, out_ready=1, 40 cycles -> out_gray sequence 00000,00001,00011,00010,... through 10000, then 00000; wrap pulses exactly once, on the transfer of 10000.
REQ-037 load_val=5'd29, load+start together, mode=1, dir=0, out_ready=1 -> emits 10011,10001,10000; done pulses on the 10000 transfer; busy falls; out_valid=0 afterwards.
REQ-038 Down, single pass from load_val=2, out_ready toggling 1,0,1,0 -> out_gray holds during ready=0 cycles; emits 00011,00001,00000; done fires once.
REQ-039 RUN at count=7, stop=1 and out_ready=1 on the same cycle -> count becomes 8, IDLE next cycle, done pulses, no wrap; a later load in IDLE is honoured.
REQ-040 Assert rst mid-RUN at count=12 with out_ready=0 -> all outputs are 0 immediately, without waiting for clk; restart without load emits 00000 first.
REQ-041 Scoreboard across all tests: every pair of consecutive transferred words differs in exactly one bit, including across a wrap.
